alu_issue_sequencer: RTL and testbench

Program-driven instruction issuer for the 8-bit in-order ALU datapath. It sits on the initiator side of the processor's operand interface. It holds a small loadable program and a 4×8 register file, fetches instructions, and drives `A`/`B`/`OpCode` into the processor. It samples `Result` and the four flags at the correct cycle, writes results back, and supports load-immediate, branch-on-zero and halt.

---
 rtl/alu_issue_sequencer.sv | 107 ++++++++++
 tb/tb_alu_issue_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: program-driven issuer for the 8-bit in-order ALU datapath
// Ports: clk/rst (sync, active-high); prog_we/prog_addr/prog_data load program words
// while idle or halted; start runs from pc 0; alu_a/alu_b/alu_op drive the processor,
// alu_result and alu_zero/carry/ovf/neg come back; busy/halted/pc/flags report status;
// dbg_sel/dbg_data read the register file combinationally.
module alu_issue_sequencer #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    input  logic          start,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [2:0]    alu_op,
    input  logic [7:0]    alu_result,
    input  logic          alu_zero,
    input  logic          alu_carry,
    input  logic          alu_ovf,
    input  logic          alu_neg,
    output logic          busy,
    output logic          halted,
    output logic [AW-1:0] pc,
    output logic [3:0]    flags,
    input  logic [1:0]    dbg_sel,
    output logic [7:0]    dbg_data
);
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, CAPTURE, HALTED} state_t;
    state_t state, state_nx;
    logic [15:0] prog [DEPTH];
    logic [15:0] ir;
    logic [3:0][7:0] rf;
    logic [2:0] op;
    logic [1:0] rd, rs1, rs2;
    logic [7:0] imm;
    logic [AW-1:0] pc_inc;
    logic is_alu, is_halt, idle_like;
    // imm overlaps rs2[0]; each op only looks at the fields it needs
    assign {op, rd, rs1, rs2} = ir[15:7];
    assign imm = ir[7:0];
    assign is_alu = op < 3'd6;
    assign is_halt = op == 3'd7 && rd[1];
    assign idle_like = state == IDLE || state == HALTED;
    assign pc_inc = pc + AW'(1);
    assign dbg_data = rf[dbg_sel];
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, HALTED: state_nx = start ? FETCH : state;
            FETCH:        state_nx = ISSUE;
            ISSUE:        state_nx = is_alu ? WAIT : is_halt ? HALTED : FETCH;
            WAIT:         state_nx = CAPTURE;
            CAPTURE:      state_nx = FETCH;
            default:      state_nx = IDLE;
        endcase
    end
    always_comb begin
        busy = !idle_like;
        halted = state == HALTED;
    end
    // program memory survives reset; writes land before a same-cycle start's first fetch
    always_ff @(posedge clk) begin
        if (prog_we && idle_like) prog[prog_addr] <= prog_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
            ir <= '0;
            rf <= '0;
            flags <= '0;
            alu_a <= '0;
            alu_b <= '0;
            alu_op <= '0;
        end else begin
            case (state)
                IDLE, HALTED: if (start) pc <= '0;
                FETCH: ir <= prog[pc];
                ISSUE: begin
                    if (is_alu) begin
                        alu_a <= rf[rs1];
                        alu_b <= rf[rs2];
                        alu_op <= op;
                    end else if (op == 3'd6) begin
                        rf[rd] <= imm;
                        pc <= pc_inc;
                    end else if (!is_halt) begin
                        pc <= flags[3] ? AW'(imm) : pc_inc;
                    end
                end
                // the processor registered our operands last edge; its result is valid now
                CAPTURE: begin
                    rf[rd] <= alu_result;
                    flags <= {alu_zero, alu_carry, alu_ovf, alu_neg};
                    pc <= pc_inc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_sequencer.sv
// tb_alu_issue_sequencer: random and directed programs checked against an instruction-level model
module tb_alu_issue_sequencer;
    logic clk = 0, rst = 1, prog_we = 0, start = 0;
    logic [3:0] prog_addr = 0, pc;
    logic [15:0] prog_data = 0;
    logic [7:0] alu_a, alu_b, alu_result, dbg_data;
    logic [2:0] alu_op;
    logic alu_zero, alu_carry, alu_ovf, alu_neg, busy, halted;
    logic [3:0] flags;
    logic [1:0] dbg_sel = 0;
    int total = 0, bad = 0;

    alu_issue_sequencer #(.DEPTH(16)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .start(start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_ovf(alu_ovf), .alu_neg(alu_neg),
        .busy(busy), .halted(halted), .pc(pc), .flags(flags), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // {Z,C,V,N,result}; C is carry-out for ADD and borrow for SUB
    function automatic logic [11:0] alu(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic c, v;
        s = '0; r = '0; c = 0; v = 0;
        case (o)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
            3'd1: begin r = a - b; c = a < b; v = (a[7] != b[7]) && (r[7] != a[7]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~(a | b);
            default: r = '0;
        endcase
        return {r == 8'd0, c, v, r[7], r};
    endfunction

    // processor stand-in: registers operands, result combinational from the registered copy
    logic [7:0] pa = 0, pb = 0;
    logic [2:0] pop = 0;
    always_ff @(posedge clk) begin
        pa <= alu_a;
        pb <= alu_b;
        pop <= alu_op;
    end
    assign {alu_zero, alu_carry, alu_ovf, alu_neg, alu_result} = alu(pop, pa, pb);

    logic [15:0] m [16];
    logic [15:0] pg [16];
    logic [7:0] r [4];
    logic [3:0] fl = 0, mpc = 0;

    function automatic logic [15:0] ai(input int o, input int d, input int s1, input int s2);
        return {3'(o), 2'(d), 2'(s1), 2'(s2), 7'b0};
    endfunction
    function automatic logic [15:0] ldi(input int d, input int v);
        return {3'b110, 2'(d), 3'b000, 8'(v)};
    endfunction
    function automatic logic [15:0] brz(input int t);
        return {3'b111, 1'b0, 4'b0, 8'(t)};
    endfunction
    localparam logic [15:0] HALT = 16'hF000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) r[i] = 0;
        fl = 0;
        mpc = 0;
    endtask

    task automatic model_run(output int cyc);
        logic [15:0] w;
        logic [11:0] x;
        mpc = 0;
        cyc = 0;
        for (int k = 0; k < 1000; k++) begin
            w = m[mpc];
            if (w[15:13] < 3'd6) begin
                x = alu(w[15:13], r[w[10:9]], r[w[8:7]]);
                r[w[12:11]] = x[7:0];
                fl = x[11:8];
                mpc = mpc + 4'd1;
                cyc += 4;
            end else if (w[15:13] == 3'd6) begin
                r[w[12:11]] = w[7:0];
                mpc = mpc + 4'd1;
                cyc += 2;
            end else if (w[12]) begin
                cyc += 2;
                break;
            end else begin
                mpc = fl[3] ? w[3:0] : mpc + 4'd1;
                cyc += 2;
            end
        end
    endtask

    task automatic load();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            prog_we = 1;
            prog_addr = 4'(i);
            prog_data = pg[i];
            m[i] = pg[i];
        end
        @(negedge clk);
        prog_we = 0;
    endtask

    task automatic rd_reg(input int i, output logic [7:0] v);
        dbg_sel = 2'(i);
        #1 v = dbg_data;
    endtask

    // meddle: while busy, try a program write to address 0 and a stray start; both must be ignored
    task automatic run(input bit meddle, input string tag, output int cyc);
        int exp_cyc;
        logic [7:0] v;
        model_run(exp_cyc);
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        cyc = 0;
        while (!halted && cyc < 2000) begin
            if (meddle && cyc == 3) begin
                prog_we = 1;
                prog_addr = 0;
                prog_data = HALT;
                start = 1;
            end
            @(negedge clk);
            prog_we = 0;
            start = 0;
            cyc++;
        end
        check({tag, ".cycles"}, cyc, exp_cyc);
        check({tag, ".halted"}, halted, 1);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".pc"}, pc, mpc);
        check({tag, ".flags"}, flags, fl);
        for (int i = 0; i < 4; i++) begin
            rd_reg(i, v);
            check($sformatf("%s.r%0d", tag, i), v, r[i]);
        end
    endtask

    initial begin
        int cyc;
        logic [7:0] v;
        for (int i = 0; i < 16; i++) pg[i] = HALT;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        check("rst.busy", busy, 0);
        check("rst.halted", halted, 0);
        check("rst.pc", pc, 0);
        check("rst.flags", flags, 0);
        check("rst.alu_a", alu_a, 0);
        check("rst.alu_b", alu_b, 0);
        check("rst.alu_op", alu_op, 0);
        for (int i = 0; i < 4; i++) begin
            rd_reg(i, v);
            check("rst.rf", v, 0);
        end

        pg[0] = ldi(0, 4); pg[1] = ldi(1, 2); pg[2] = ai(0, 2, 0, 1); pg[3] = HALT;
        load();
        run(0, "add", cyc);
        check("add.latency", cyc, 10);
        rd_reg(2, v);
        check("add.r2", v, 8'h06);
        check("add.flags", flags, 4'b0000);
        check("add.alu_a", alu_a, 8'h04);
        check("add.alu_b", alu_b, 8'h02);
        check("add.alu_op", alu_op, 3'd0);

        pg[3] = ai(1, 3, 1, 0); pg[4] = HALT;
        load();
        run(0, "sub", cyc);
        rd_reg(3, v);
        check("sub.r3", v, 8'hFE);
        check("sub.flags", flags, 4'b0101);

        pg[0] = ldi(3, 8'hFF); pg[1] = ai(5, 2, 3, 3); pg[2] = brz(5);
        pg[3] = HALT; pg[4] = HALT; pg[5] = HALT;
        load();
        run(0, "nor_taken", cyc);
        check("nor_taken.pc5", pc, 5);
        rd_reg(2, v);
        check("nor_taken.r2", v, 8'h00);
        check("nor_taken.flags", flags, 4'b1000);

        pg[0] = ldi(3, 8'h0F);
        load();
        run(0, "nor_not_taken", cyc);
        check("nor_not_taken.pc3", pc, 3);
        run(1, "meddle", cyc);
        run(0, "after_meddle", cyc);

        pg[0] = ldi(0, 1); pg[1] = ldi(1, 1); pg[2] = ai(0, 2, 0, 1); pg[3] = HALT;
        load();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (6) @(negedge clk);
        check("wait.alu_a", alu_a, 8'h01);
        rst = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
        rd_reg(2, v);
        check("wait_rst.r2", v, 0);
        check("wait_rst.flags", flags, 0);
        check("wait_rst.busy", busy, 0);
        check("wait_rst.halted", halted, 0);
        check("wait_rst.pc", pc, 0);
        run(0, "wait_rerun", cyc);

        for (int i = 0; i < 16; i++) pg[i] = ldi(i % 4, i * 3);
        load();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (30) @(negedge clk);
        check("wrap.pc15", pc, 15);
        repeat (2) @(negedge clk);
        check("wrap.pc0", pc, 0);
        check("wrap.busy", busy, 1);
        check("wrap.halted", halted, 0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
        check("wrap_rst.busy", busy, 0);

        for (int p = 0; p < 20; p++) begin
            for (int i = 0; i < 15; i++) begin
                int k;
                k = $urandom_range(0, 9);
                if (k < 5) pg[i] = ai($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                else if (k < 8) pg[i] = ldi($urandom_range(0, 3), $urandom_range(0, 255));
                else if (k == 8) pg[i] = brz($urandom_range(15, i + 1));
                else pg[i] = HALT;
            end
            pg[15] = HALT;
            load();
            run(p % 4 == 0, $sformatf("rand%0d", p), cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
